// File: rtl/i2s_stereo_tx.sv
// rtl/i2s_stereo_tx.sv - stereo I2S / left-justified transmitter with a one-deep sample holding buffer
// Frames are rebuilt into a shift register at each frame load; dac is its MSB.
module i2s_stereo_tx #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int SLOT_WIDTH     = 32,
  parameter int SCLK_DIV       = 4,
  parameter int LEFT_JUSTIFIED = 0,
  parameter int UNDERRUN_HOLD  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    sclk,
  output logic                    lrck,
  output logic                    dac,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] LR_LO    =
    BIT_W'((LEFT_JUSTIFIED != 0) ? SLOT_WIDTH : SLOT_WIDTH - 1);

  if ((SCLK_DIV < 2) || ((SCLK_DIV % 2) != 0)) begin : g_bad_div
    $error("i2s_stereo_tx: SCLK_DIV must be even and >= 2");
  end
  if ((SAMPLE_WIDTH < 1) || (SAMPLE_WIDTH > SLOT_WIDTH)) begin : g_bad_width
    $error("i2s_stereo_tx: SAMPLE_WIDTH must be in 1..SLOT_WIDTH");
  end

  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [SAMPLE_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_r_q;
  logic                    hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [SLOT_WIDTH-1:0]   slot_l, slot_r;
  logic                    sclk_q, sclk_d;
  logic                    lrck_q, lrck_d;
  logic                    underrun_q, underrun_d;
  logic                    tick, load, accept;

  always_comb begin
    tick        = (div_q == DIV_LAST);
    load        = tick && (bit_q == BIT_LAST);
    accept      = sample_valid && !hold_full_q;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    bit_d       = bit_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;

    if (load) begin
      bit_d = '0;
    end else if (tick) begin
      bit_d = bit_q + BIT_W'(1);
    end

    // The load only sees the registered flag: a same-cycle accept waits a frame.
    if (load) begin
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
        if (UNDERRUN_HOLD == 0) begin
          act_l_d = '0;
          act_r_d = '0;
        end
      end
    end
    if (accept) begin
      hold_full_d = 1'b1;
    end

    slot_l  = SLOT_WIDTH'(act_l_d) << (SLOT_WIDTH - SAMPLE_WIDTH);
    slot_r  = SLOT_WIDTH'(act_r_d) << (SLOT_WIDTH - SAMPLE_WIDTH);
    frame_d = frame_q;
    if (load) begin
      frame_d = {slot_l, slot_r};
    end else if (tick) begin
      frame_d = frame_q << 1;
    end

    sclk_d = (div_d >= DIV_HALF);
    if (LEFT_JUSTIFIED != 0) begin
      lrck_d = (bit_d >= LR_LO);
    end else begin
      lrck_d = (bit_d >= LR_LO) && (bit_d != BIT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      bit_q       <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      sclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      bit_q       <= bit_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      sclk_q      <= sclk_d;
      lrck_q      <= lrck_d;
      underrun_q  <= underrun_d;
      if (accept) begin
        hold_l_q <= sample_l;
        hold_r_q <= sample_r;
      end
    end
  end

  assign sample_ready = !hold_full_q;
  assign sclk         = sclk_q;
  assign lrck         = lrck_q;
  assign dac          = frame_q[FRAME_BITS-1];
  assign underrun     = underrun_q;
  assign frame_start  = !reset && (div_q == '0) && (bit_q == '0);

endmodule

// File: doc/i2s_stereo_tx.md
# i2s_stereo_tx

Parametrised stereo I2S transmitter with a valid/ready sample input and a one-deep holding buffer. It replaces the fixed mono 16-in-32 shifter inside the core top level. It runs entirely in the audio master-clock domain and generates sclk, lrck and serial data for the Pocket audio DAC. Word width, slot width, bit-clock divide, framing mode and underrun policy are all parameters.

## Interface
- SAMPLE_WIDTH, 16: bits per channel sample, two's complement. Legal range 1..SLOT_WIDTH.
- SLOT_WIDTH, 32: bit periods per channel slot. One frame is 2*SLOT_WIDTH bits.
- SCLK_DIV, 4: clk cycles per bit period. Must be even and ≥2; elaboration error otherwise.
- LEFT_JUSTIFIED, 0: 0 = I2S framing (lrck leads MSB by one bit); 1 = left-justified (lrck aligned with MSB).
- UNDERRUN_HOLD, 1: 1 = replay the last frame on underrun; 0 = send zeros.
- clk  in  1  audio master clock (12.288 MHz in the Pocket build).
- reset  in  1  asynchronous, active-high.
- sample_l  in  SAMPLE_WIDTH  left sample.
- sample_r  in  SAMPLE_WIDTH  right sample.
- sample_valid  in  1  sample pair offered.
- sample_ready  out  1  holding buffer empty; equals !holding_full (combinational from a register).
- sclk  out  1  bit clock, registered.
- lrck  out  1  word select, 0 = left, registered.
- dac  out  1  serial data, MSB first, registered.
- frame_start  out  1  one-cycle pulse at the first clk of each frame.
- underrun  out  1  one-cycle pulse when a frame loads with the holding buffer empty.

## Operation
- Counters: div_cnt runs 0..SCLK_DIV-1. bit_idx runs 0..2*SLOT_WIDTH-1. A bit tick occurs when div_cnt==SCLK_DIV-1; on a tick bit_idx increments and wraps to 0.
- sclk is 0 while div_cnt < SCLK_DIV/2 and 1 otherwise. dac and lrck change only when div_cnt returns to 0 (the sclk falling edge), so the receiver samples on the sclk rising edge.
- Serial stream for bit_idx b:
  - b < SLOT_WIDTH: dac = L[SAMPLE_WIDTH-1-b] if b < SAMPLE_WIDTH, else 0.
  - b ≥ SLOT_WIDTH: same rule applied to R with b-SLOT_WIDTH.
- lrck in left-justified mode: 1 for b in SLOT_WIDTH..2*SLOT_WIDTH-1, 0 otherwise.
- lrck in I2S mode: 1 for b in SLOT_WIDTH-1..2*SLOT_WIDTH-2, 0 otherwise. The data stream is unchanged; only lrck leads by one bit.
- Buffering: an accept happens when sample_valid && sample_ready. An accept writes the pair to the holding register and sets holding_full.
- Frame load occurs on the tick where bit_idx wraps from 2*SLOT_WIDTH-1 to 0:
  - holding_full=1: active ← holding, holding_full ← 0.
  - holding_full=0: active ← active if UNDERRUN_HOLD, else 0; underrun pulses.
- Simultaneous accept and frame load (holding empty): the load sees the registered holding_full=0. It underruns, and the new pair stays in holding for the next frame. There is no bypass.
- Holding full in the load cycle: sample_ready=0 that cycle, so accept and transfer never collide. sample_ready returns to 1 the cycle after the load.
- Reset, at any time including mid-frame:
  - div_cnt, bit_idx, active and holding all clear; the pending pair is dropped.
  - Outputs immediately: sclk=0, lrck=0, dac=0, frame_start=0, underrun=0, sample_ready=1.
  - sample_valid is ignored while reset is high.
- After reset release the first frame starts with bit_idx=0 and transmits zeros.

## Timing
- Bit period = SCLK_DIV clk cycles. Frame = 2*SLOT_WIDTH*SCLK_DIV cycles (256 with defaults, i.e. 48 kHz at 12.288 MHz).
- frame_start is high in the cycle where div_cnt==0 and bit_idx==0. underrun, when it fires, is high in that same cycle.
- Latency from accept to first MSB on dac: the remainder of the current frame, up to one full frame.
- dac shows the new frame's left MSB in the same cycle frame_start is high.

## Test plan
- Reset values: assert reset mid-run → sclk/lrck/dac/frame_start/underrun = 0 and sample_ready=1 in the same cycle. After release, frame_start first fires on the first cycle.
- Left-justified, defaults: accept L=16'h8001, R=16'h7FFE during frame 0 → frame 1 dac bits are 1, 14×0, 1, 16×0, then 0, 14×1, 0, 16×0. lrck is 0 for 32 bits, then 1. Frame period is 256 clk.
- I2S mode, defaults: same data → lrck rises at bit_idx 31 and falls at bit_idx 63; dac stream is identical to the left-justified case.
- Underrun: after one pair, supply nothing → underrun pulses once per frame. UNDERRUN_HOLD=1 repeats 8001/7FFE; UNDERRUN_HOLD=0 sends all-zero frames.
- Backpressure: hold sample_valid high with pairs A then B → A is accepted immediately and sample_ready drops. B is accepted the cycle after the next frame load. A is transmitted before B, and no underrun occurs.
- Parameter sweep: SAMPLE_WIDTH=24, SLOT_WIDTH=24, SCLK_DIV=2, L=24'hA5A5A5 → 24 bits MSB first with no padding. Frame = 96 clk; sclk toggles every clk.
